hyper_txn_arbiter: RTL and testbench
====================================

Name: hyper_txn_arbiter

Overview:
- Shares the single uDMA HyperBus channel between NB_REQ requesters, such as cluster DMA, boot loader and debug.
- Arbitrates pending transfer descriptors round-robin and latches the winner.
- Programs the HyperBus config port with a fixed 4-write sequence: external address, L2 address, size, control/start.
- Waits for the matching read or write end-of-transfer event, then returns a done/error pulse to the owning requester.

Parameters:
- NB_REQ, 4, number of requesters (2..8).
- L2_AWIDTH, 19, L2 address width.
- SIZE_WIDTH, 20, transfer size width in bytes.
- CFG_AWIDTH, 6, config address width.
- REG_EXT_ADDR, 6'h00, config offset for the external (HyperRAM) address.
- REG_L2_ADDR, 6'h04, config offset for the L2 address.
- REG_SIZE, 6'h08, config offset for the size.
- REG_CTRL, 6'h0C, config offset for the control/start word.
- TIMEOUT_CYC, 16'hFFFF, watchdog limit in sys_clk_i cycles (optional feature only).

Ports:
- sys_clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- req_valid_i  in  NB_REQ  descriptor pending, one bit per requester
- req_ready_o  out  NB_REQ  one-cycle grant/accept pulse
- req_rwn_i  in  NB_REQ  1 = read from HyperRAM into L2, 0 = write
- req_ext_addr_i  in  NB_REQ*32  external byte address per requester
- req_l2_addr_i  in  NB_REQ*L2_AWIDTH  L2 address per requester
- req_size_i  in  NB_REQ*SIZE_WIDTH  byte count per requester
- done_o  out  NB_REQ  one-cycle completion pulse
- err_o  out  NB_REQ  qualifies done_o as an error (valid only with done_o)
- cfg_valid_o  out  1  config write request
- cfg_rwn_o  out  1  config direction; always 0 (write)
- cfg_addr_o  out  CFG_AWIDTH  config register offset
- cfg_data_o  out  32  config write data
- cfg_ready_i  in  1  config write accepted
- evt_eot_rd_i  in  1  read end-of-transfer pulse
- evt_eot_wr_i  in  1  write end-of-transfer pulse
- busy_o  out  1  high in every state other than IDLE
- grant_id_o  out  $clog2(NB_REQ)  index of the current owner

Behaviour:
- Reset: rstn_i is asynchronous active-low; the clock is sys_clk_i.
  - State goes to IDLE and all outputs go to 0.
  - last_grant resets to NB_REQ-1, so requester 0 has top priority first.
  - Reset mid-operation drops cfg_valid_o immediately and abandons the transfer; no done_o is issued.
- State machine: IDLE -> CFG_EXT -> CFG_L2 -> CFG_SIZE -> CFG_START -> WAIT_EOT -> DONE -> IDLE.
- IDLE:
  - If any req_valid_i bit is set, pick the first set index searching from (last_grant+1) mod NB_REQ upward with wrap.
  - Pulse req_ready_o[g] in that same cycle, latch the descriptor, and update last_grant and grant_id_o.
  - Next state is CFG_EXT. If the latched size is 0, go to DONE with error instead and skip all config writes.
- Requester contract: req_valid_i must stay high with a stable descriptor until ready; a requester may keep valid high for its next descriptor.
- Config writes (CFG_* states):
  - cfg_valid_o is high from state entry; cfg_addr_o and cfg_data_o stay stable until the cycle with cfg_ready_i=1, then the FSM advances.
  - Minimum 1 cycle per write; any number of stall cycles is allowed.
  - Data per state: CFG_EXT = ext_addr; CFG_L2 = zero-extended l2_addr; CFG_SIZE = zero-extended size; CFG_START = {30'b0, rwn, 1'b1}.
- WAIT_EOT:
  - cfg_valid_o is low.
  - Completes on evt_eot_rd_i if rwn=1, or on evt_eot_wr_i if rwn=0.
  - An event of the opposite type is ignored. If both arrive in one cycle, the matching one completes.
- DONE: done_o[g]=1 for exactly one cycle, with err_o[g] as set; always returns to IDLE.
- Latency: with cfg_ready_i tied high, grant at cycle N gives cfg writes in cycles N+1..N+4 and WAIT_EOT from N+5. An EOT at cycle M gives done_o at M+1, and the next grant can occur at M+2.
- Only one transfer is outstanding at any time; no queueing beyond the requesters' own valid bits.

Optional Feature:
- Macro: HYPER_ARB_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entering WAIT_EOT and increments each cycle there. On reaching TIMEOUT_CYC without a matching EOT, go to DONE with done_o=1 and err_o=1. A late EOT arriving in IDLE is ignored.
- Undefined: no counter is instantiated and WAIT_EOT waits indefinitely.

Test Plan:
- Single read, requester 1, ext=0x0000_1000, l2=0x1_0000, size=256, cfg_ready tied 1 -> cfg writes in order (0x00,0x1000), (0x04,0x10000), (0x08,0x100), (0x0C,0x3); evt_eot_rd at cycle M -> done_o=4'b0010 at M+1, err_o=0.
- Round-robin: all 4 requesters valid continuously -> grant order 0,1,2,3,0; grant_id_o follows; exactly one req_ready_o pulse per transfer.
- Config backpressure: cfg_ready_i low for 3 cycles on the CFG_SIZE write -> cfg_addr_o=0x08 and its data held stable for 4 cycles; sequence then continues.
- Wrong event: write transfer; evt_eot_rd pulsed, then evt_eot_wr 5 cycles later -> done only after evt_eot_wr. Same-cycle rd+wr on a write transfer -> completes.
- Zero size: requester 2, size=0 -> req_ready_o[2] pulse, no cfg_valid_o, done_o[2]=err_o[2]=1 two cycles later.
- Reset mid-op: assert rstn_i low during CFG_L2 -> cfg_valid_o, busy_o and req_ready_o go to 0 asynchronously; after release, requester 0 has top priority. With HYPER_ARB_TIMEOUT_EN and TIMEOUT_CYC=100: no EOT -> done+err 101 cycles after WAIT_EOT entry.

Source files
------------

// File: rtl/hyper_txn_arbiter.sv
// Round-robin owner of the uDMA HyperBus channel: grants one requester, programs the
// four config writes, waits for the matching EOT and returns done/err. Watchdog: HYPER_ARB_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no owner; round-robin pick and accept of a pending descriptor
// CFG_EXT   | config write of external address (or zero-size reject, no write)
// CFG_L2    | config write of L2 address
// CFG_SIZE  | config write of byte count
// CFG_START | config write of control word, starts the transfer
// WAIT_EOT  | waiting for the end-of-transfer event matching the direction
// DONE      | done_o/err_o pulse to the owner
module hyper_txn_arbiter #(
  parameter int NB_REQ     = 4,
  parameter int L2_AWIDTH  = 19,
  parameter int SIZE_WIDTH = 20,
  parameter int CFG_AWIDTH = 6,
  parameter logic [CFG_AWIDTH-1:0] REG_EXT_ADDR = 6'h00,
  parameter logic [CFG_AWIDTH-1:0] REG_L2_ADDR  = 6'h04,
  parameter logic [CFG_AWIDTH-1:0] REG_SIZE     = 6'h08,
  parameter logic [CFG_AWIDTH-1:0] REG_CTRL     = 6'h0C
`ifdef HYPER_ARB_TIMEOUT_EN
  , parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
`endif
) (
  input  logic                           sys_clk_i,
  input  logic                           rstn_i,
  input  logic [NB_REQ-1:0]              req_valid_i,
  output logic [NB_REQ-1:0]              req_ready_o,
  input  logic [NB_REQ-1:0]              req_rwn_i,
  input  logic [NB_REQ*32-1:0]           req_ext_addr_i,
  input  logic [NB_REQ*L2_AWIDTH-1:0]    req_l2_addr_i,
  input  logic [NB_REQ*SIZE_WIDTH-1:0]   req_size_i,
  output logic [NB_REQ-1:0]              done_o,
  output logic [NB_REQ-1:0]              err_o,
  output logic                           cfg_valid_o,
  output logic                           cfg_rwn_o,
  output logic [CFG_AWIDTH-1:0]          cfg_addr_o,
  output logic [31:0]                    cfg_data_o,
  input  logic                           cfg_ready_i,
  input  logic                           evt_eot_rd_i,
  input  logic                           evt_eot_wr_i,
  output logic                           busy_o,
  output logic [$clog2(NB_REQ)-1:0]      grant_id_o
);

  localparam int IDW = $clog2(NB_REQ);

  typedef enum logic [2:0] {
    IDLE, CFG_EXT, CFG_L2, CFG_SIZE, CFG_START, WAIT_EOT, DONE
  } state_t;

  state_t                 state_q;
  logic [IDW-1:0]         last_grant_q;
  logic                   rwn_q;
  logic                   zero_q;
  logic [L2_AWIDTH-1:0]   l2_q;
  logic [SIZE_WIDTH-1:0]  size_q;
  logic                   pick_found;
  logic [IDW-1:0]         pick_idx;
  int                     rr_idx;
  logic [31:0]            sel_ext;
  logic [L2_AWIDTH-1:0]   sel_l2;
  logic [SIZE_WIDTH-1:0]  sel_size;
  logic                   eot_match;
`ifdef HYPER_ARB_TIMEOUT_EN
  logic [15:0]            tmo_cnt_q;
`endif

  // Search starts just above the previous owner so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_idx     = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      rr_idx = (int'(last_grant_q) + 1 + i) % NB_REQ;
      if (!pick_found && req_valid_i[rr_idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(rr_idx);
      end
    end
  end

  assign sel_ext   = req_ext_addr_i[pick_idx*32 +: 32];
  assign sel_l2    = req_l2_addr_i[pick_idx*L2_AWIDTH +: L2_AWIDTH];
  assign sel_size  = req_size_i[pick_idx*SIZE_WIDTH +: SIZE_WIDTH];
  assign eot_match = rwn_q ? evt_eot_rd_i : evt_eot_wr_i;
  assign cfg_rwn_o = 1'b0;

  // Accept must land in the arbitration cycle itself; gating with rstn_i keeps it quiet in reset.
  always_comb begin
    req_ready_o = '0;
    if (rstn_i && state_q == IDLE && pick_found) req_ready_o[pick_idx] = 1'b1;
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NB_REQ - 1);
      rwn_q        <= 1'b0;
      zero_q       <= 1'b0;
      l2_q         <= '0;
      size_q       <= '0;
      done_o       <= '0;
      err_o        <= '0;
      cfg_valid_o  <= 1'b0;
      cfg_addr_o   <= '0;
      cfg_data_o   <= '0;
      busy_o       <= 1'b0;
      grant_id_o   <= '0;
`ifdef HYPER_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      done_o <= '0;
      err_o  <= '0;
      case (state_q)
        IDLE: if (pick_found) begin
          last_grant_q <= pick_idx;
          grant_id_o   <= pick_idx;
          rwn_q        <= req_rwn_i[pick_idx];
          l2_q         <= sel_l2;
          size_q       <= sel_size;
          zero_q       <= (sel_size == '0);
          busy_o       <= 1'b1;
          state_q      <= CFG_EXT;
          // A zero-length descriptor passes through CFG_EXT without ever raising cfg_valid_o.
          if (sel_size != '0) begin
            cfg_valid_o <= 1'b1;
            cfg_addr_o  <= REG_EXT_ADDR;
            cfg_data_o  <= sel_ext;
          end
        end
        CFG_EXT: begin
          if (zero_q) begin
            done_o[grant_id_o] <= 1'b1;
            err_o[grant_id_o]  <= 1'b1;
            state_q            <= DONE;
          end else if (cfg_ready_i) begin
            cfg_addr_o <= REG_L2_ADDR;
            cfg_data_o <= 32'(l2_q);
            state_q    <= CFG_L2;
          end
        end
        CFG_L2: if (cfg_ready_i) begin
          cfg_addr_o <= REG_SIZE;
          cfg_data_o <= 32'(size_q);
          state_q    <= CFG_SIZE;
        end
        CFG_SIZE: if (cfg_ready_i) begin
          cfg_addr_o <= REG_CTRL;
          cfg_data_o <= {30'b0, rwn_q, 1'b1};
          state_q    <= CFG_START;
        end
        CFG_START: if (cfg_ready_i) begin
          cfg_valid_o <= 1'b0;
          state_q     <= WAIT_EOT;
`ifdef HYPER_ARB_TIMEOUT_EN
          tmo_cnt_q   <= '0;
`endif
        end
        WAIT_EOT: begin
          if (eot_match) begin
            done_o[grant_id_o] <= 1'b1;
            state_q            <= DONE;
          end
`ifdef HYPER_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TIMEOUT_CYC) begin
            done_o[grant_id_o] <= 1'b1;
            err_o[grant_id_o]  <= 1'b1;
            state_q            <= DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
`endif
        end
        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_txn_arbiter.sv
// Directed bench for hyper_txn_arbiter: one task per scenario with inline checks.
module tb_hyper_txn_arbiter;

  localparam int NB = 4;

  logic            sys_clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NB-1:0]   req_valid = '0;
  logic [NB-1:0]   req_ready;
  logic [NB-1:0]   req_rwn = '0;
  logic [NB*32-1:0] req_ext_addr = '0;
  logic [NB*19-1:0] req_l2_addr = '0;
  logic [NB*20-1:0] req_size = '0;
  logic [NB-1:0]   done;
  logic [NB-1:0]   err;
  logic            cfg_valid;
  logic            cfg_rwn;
  logic [5:0]      cfg_addr;
  logic [31:0]     cfg_data;
  logic            cfg_ready = 1'b1;
  logic            evt_rd = 1'b0;
  logic            evt_wr = 1'b0;
  logic            busy;
  logic [1:0]      grant_id;

  int vectors = 0;
  int miscompares = 0;
  int rdy_cnt = 0;

  hyper_txn_arbiter #(
    .NB_REQ(NB)
`ifdef HYPER_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(16'd100)
`endif
  ) dut (
    .sys_clk_i(sys_clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rwn_i(req_rwn),
    .req_ext_addr_i(req_ext_addr), .req_l2_addr_i(req_l2_addr), .req_size_i(req_size),
    .done_o(done), .err_o(err),
    .cfg_valid_o(cfg_valid), .cfg_rwn_o(cfg_rwn), .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data),
    .cfg_ready_i(cfg_ready), .evt_eot_rd_i(evt_rd), .evt_eot_wr_i(evt_wr),
    .busy_o(busy), .grant_id_o(grant_id)
  );

  always #5 sys_clk = ~sys_clk;

  always begin
    @(negedge sys_clk);
    #3;
    if (|req_ready) rdy_cnt++;
  end

  task automatic nxt();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic set_desc(input int i, input logic rwn, input logic [31:0] ext,
                          input logic [18:0] l2, input logic [19:0] sz);
    req_rwn[i]             = rwn;
    req_ext_addr[i*32 +: 32] = ext;
    req_l2_addr[i*19 +: 19]  = l2;
    req_size[i*20 +: 20]     = sz;
  endtask

  task automatic do_reset();
    nxt();
    rstn = 1'b0;
    nxt();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    #12;
    obs = {req_ready, done, err, cfg_valid, cfg_rwn, busy, grant_id};
    vectors++;
    if (obs !== 17'h0) begin miscompares++; $display("FAIL reset_held: got %h expected 0", obs); end
    nxt();
    rstn = 1'b1;
    nxt();
    obs = {req_ready, done, err, cfg_valid, cfg_rwn, busy, grant_id};
    vectors++;
    if (obs !== 17'h0 || cfg_addr !== 6'h0 || cfg_data !== 32'h0) begin
      miscompares++; $display("FAIL reset_release: got %h/%h/%h expected 0", obs, cfg_addr, cfg_data);
    end
  endtask

  task automatic test_single_read();
    logic [5:0]  ea [4] = '{6'h00, 6'h04, 6'h08, 6'h0C};
    logic [31:0] ed [4] = '{32'h1000, 32'h10000, 32'h100, 32'h3};
    nxt();
    set_desc(1, 1'b1, 32'h0000_1000, 19'h1_0000, 20'd256);
    req_valid = 4'b0010;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL rd_grant: got %b expected 0010", req_ready); end
    for (int k = 0; k < 4; k++) begin
      nxt();
      if (k == 0) req_valid = '0;
      vectors++;
      if ({cfg_valid, cfg_addr, cfg_data, grant_id} !== {1'b1, ea[k], ed[k], 2'd1}) begin
        miscompares++;
        $display("FAIL rd_cfg%0d: got v=%b a=%h d=%h g=%0d expected v=1 a=%h d=%h g=1",
                 k, cfg_valid, cfg_addr, cfg_data, grant_id, ea[k], ed[k]);
      end
    end
    nxt();
    vectors++;
    if ({cfg_valid, busy} !== 2'b01) begin miscompares++; $display("FAIL rd_wait: got %b expected 01", {cfg_valid, busy}); end
    evt_rd = 1'b1;
    nxt();
    evt_rd = 1'b0;
    vectors++;
    if ({done, err} !== {4'b0010, 4'b0000}) begin miscompares++; $display("FAIL rd_done: got %b expected 00100000", {done, err}); end
    nxt();
    vectors++;
    if ({done, busy} !== 5'b0) begin miscompares++; $display("FAIL rd_idle: got %b expected 00000", {done, busy}); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    int rd0;
    do_reset();
    for (int i = 0; i < NB; i++) set_desc(i, 1'b0, 32'h100 * (i + 1), 19'(i * 16), 20'd16);
    nxt();
    req_valid = 4'hF;
    #1;
    rd0 = rdy_cnt;
    for (int t = 0; t < 5; t++) begin
      exp = 4'b0001 << (t % 4);
      vectors++;
      if (req_ready !== exp) begin miscompares++; $display("FAIL rr_ready%0d: got %b expected %b", t, req_ready, exp); end
      nxt();
      vectors++;
      if (grant_id !== 2'(t % 4)) begin miscompares++; $display("FAIL rr_gid%0d: got %0d expected %0d", t, grant_id, t % 4); end
      repeat (4) nxt();
      evt_wr = 1'b1;
      nxt();
      evt_wr = 1'b0;
      if (t == 4) req_valid = '0;
      #1;
      vectors++;
      if (done !== exp) begin miscompares++; $display("FAIL rr_done%0d: got %b expected %b", t, done, exp); end
      nxt();
      #1;
    end
    #3;
    vectors++;
    if (rdy_cnt - rd0 !== 5) begin miscompares++; $display("FAIL rr_pulses: got %0d expected 5", rdy_cnt - rd0); end
  endtask

  task automatic test_backpressure();
    nxt();
    set_desc(3, 1'b1, 32'hABCD_0000, 19'h7_1234, 20'h0_0040);
    req_valid = 4'b1000;
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_grant: got %b expected 1000", req_ready); end
    nxt();
    req_valid = '0;
    nxt();
    nxt();
    cfg_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) nxt();
      if (s == 3) cfg_ready = 1'b1;
      vectors++;
      if ({cfg_valid, cfg_addr, cfg_data} !== {1'b1, 6'h08, 32'h40}) begin
        miscompares++; $display("FAIL bp_hold%0d: got v=%b a=%h d=%h expected v=1 a=08 d=40", s, cfg_valid, cfg_addr, cfg_data);
      end
    end
    nxt();
    vectors++;
    if ({cfg_valid, cfg_addr, cfg_data} !== {1'b1, 6'h0C, 32'h3}) begin
      miscompares++; $display("FAIL bp_start: got v=%b a=%h d=%h expected v=1 a=0c d=3", cfg_valid, cfg_addr, cfg_data);
    end
    nxt();
    evt_rd = 1'b1;
    nxt();
    evt_rd = 1'b0;
    vectors++;
    if ({done, err} !== {4'b1000, 4'b0000}) begin miscompares++; $display("FAIL bp_done: got %b expected 10000000", {done, err}); end
    nxt();
  endtask

  task automatic test_wrong_event();
    nxt();
    set_desc(0, 1'b0, 32'h2000, 19'h100, 20'd4);
    req_valid = 4'b0001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL we_grant: got %b expected 0001", req_ready); end
    nxt();
    req_valid = '0;
    repeat (4) nxt();
    evt_rd = 1'b1;
    nxt();
    evt_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt();
      vectors++;
      if ({busy, done} !== 5'b10000) begin miscompares++; $display("FAIL we_ignore%0d: got %b expected 10000", i, {busy, done}); end
    end
    nxt();
    evt_wr = 1'b1;
    nxt();
    evt_wr = 1'b0;
    vectors++;
    if ({done, err} !== {4'b0001, 4'b0000}) begin miscompares++; $display("FAIL we_done: got %b expected 00010000", {done, err}); end
    nxt();
    req_valid = 4'b0001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL both_grant: got %b expected 0001", req_ready); end
    nxt();
    req_valid = '0;
    repeat (4) nxt();
    evt_rd = 1'b1;
    evt_wr = 1'b1;
    nxt();
    evt_rd = 1'b0;
    evt_wr = 1'b0;
    vectors++;
    if ({done, err} !== {4'b0001, 4'b0000}) begin miscompares++; $display("FAIL both_done: got %b expected 00010000", {done, err}); end
    nxt();
  endtask

  task automatic test_zero_size();
    nxt();
    set_desc(2, 1'b0, 32'h3000, 19'h0, 20'd0);
    req_valid = 4'b0100;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL zs_grant: got %b expected 0100", req_ready); end
    nxt();
    req_valid = '0;
    vectors++;
    if ({cfg_valid, busy, done} !== 6'b010000) begin miscompares++; $display("FAIL zs_step1: got %b expected 010000", {cfg_valid, busy, done}); end
    nxt();
    vectors++;
    if ({cfg_valid, done, err} !== {1'b0, 4'b0100, 4'b0100}) begin
      miscompares++; $display("FAIL zs_done: got %b expected 001000100", {cfg_valid, done, err});
    end
    nxt();
    vectors++;
    if ({busy, done} !== 5'b0) begin miscompares++; $display("FAIL zs_idle: got %b expected 00000", {busy, done}); end
  endtask

  task automatic test_reset_midop();
    nxt();
    set_desc(1, 1'b0, 32'h4000, 19'h200, 20'd8);
    set_desc(0, 1'b0, 32'h5000, 19'h300, 20'd8);
    req_valid = 4'b0010;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL rm_grant: got %b expected 0010", req_ready); end
    nxt();
    req_valid = '0;
    nxt();
    vectors++;
    if ({cfg_valid, cfg_addr} !== {1'b1, 6'h04}) begin miscompares++; $display("FAIL rm_l2: got %b %h expected 1 04", cfg_valid, cfg_addr); end
    req_valid = 4'hF;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({cfg_valid, busy, req_ready, done} !== 10'b0) begin
      miscompares++; $display("FAIL rm_async: got %b expected 0", {cfg_valid, busy, req_ready, done});
    end
    nxt();
    rstn = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rm_prio: got %b expected 0001", req_ready); end
    nxt();
    req_valid = '0;
    vectors++;
    if ({grant_id, busy, done} !== 7'b0010000) begin miscompares++; $display("FAIL rm_owner: got %b expected 0010000", {grant_id, busy, done}); end
    do_reset();
  endtask

`ifdef HYPER_ARB_TIMEOUT_EN
  task automatic test_timeout();
    nxt();
    set_desc(3, 1'b1, 32'h6000, 19'h40, 20'd1);
    req_valid = 4'b1000;
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL to_grant: got %b expected 1000", req_ready); end
    nxt();
    req_valid = '0;
    repeat (104) nxt();
    vectors++;
    if ({busy, done} !== 5'b10000) begin miscompares++; $display("FAIL to_early: got %b expected 10000", {busy, done}); end
    nxt();
    vectors++;
    if ({done, err} !== {4'b1000, 4'b1000}) begin miscompares++; $display("FAIL to_done: got %b expected 10001000", {done, err}); end
    nxt();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_wrong_event();
    test_zero_size();
    test_reset_midop();
`ifdef HYPER_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
